// File: rtl/default_drive_bank_pkg.sv
// -----------------------------------------------------------------------------
// default_drive_bank_pkg
// Purpose : Shared types and helpers for the default_drive_bank slice.
//           Holds the sweep FSM state encoding and the elaboration-time helper
//           that computes each channel's power-on / revert value.
// Contents: state_t        - FSM states {IDLE, SWEEP}
//           default_value  - (base + idx) truncated to 'width' bits
// -----------------------------------------------------------------------------
package default_drive_bank_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Sum in 32 bits first, then mask down to the channel width so that large
    // bases or indices wrap the same way a WIDTH-bit register would.
    function automatic logic [31:0] default_value(input int base, input int idx, input int width);
        logic [31:0] sum;
        logic [31:0] mask;
        sum  = 32'(base + idx);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return sum & mask;
    endfunction

endpackage

// File: rtl/default_drive_bank_if.sv
// -----------------------------------------------------------------------------
// default_drive_bank_if
// Purpose : Valid/ready write port of the default_drive_bank.
// Signals : wr_valid  - write request (master -> slave)
//           wr_ready  - slave can accept (slave -> master)
//           wr_idx    - target channel, IW bits
//           wr_data   - value to drive, WIDTH bits
// Modports: master (write source), slave (the bank)
// -----------------------------------------------------------------------------
interface default_drive_bank_if #(
    parameter int IW    = 2,
    parameter int WIDTH = 5
);

    logic             wr_valid;
    logic             wr_ready;
    logic [IW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_idx,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_idx,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/default_drive_bank_channel.sv
// -----------------------------------------------------------------------------
// default_drive_bank_channel
// Purpose : One output channel: a data register that powers up at its default,
//           a driven flag, and (optionally) an idle timeout that reverts it.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           i_wr_en      - load i_wr_data and set driven
//           i_wr_data    - value to load
//           i_revert     - return to default and clear driven
//           o_data       - registered channel value
//           o_driven     - registered driven flag
// Macro   : DEFAULT_DRIVE_BANK_TIMEOUT_EN adds the TIMEOUT parameter and the
//           idle counter; without it a driven value holds indefinitely.
// -----------------------------------------------------------------------------
module default_drive_bank_channel #(
    parameter int          WIDTH       = 5,
    parameter logic [31:0] DEFAULT_VAL = 32'd0
`ifdef DEFAULT_DRIVE_BANK_TIMEOUT_EN
    ,
    parameter int          TIMEOUT     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_revert,
    output logic [WIDTH-1:0] o_data,
    output logic             o_driven
);

    localparam logic [WIDTH-1:0] DEF = DEFAULT_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_data;
    logic             r_driven;
    logic             w_revert;

`ifdef DEFAULT_DRIVE_BANK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_idle_cnt;
    logic          w_expire;

    // The edge that would move the count to TIMEOUT is the revert edge, so
    // the channel shows its written value for exactly TIMEOUT cycles.
    assign w_expire = r_driven && (r_idle_cnt == CW'(TIMEOUT - 1));
    assign w_revert = i_revert || w_expire;

    // Idle counter: restarts on any write or revert, otherwise ticks while
    // the channel holds a written value.
    always_ff @(posedge clk) begin
        if (rst || i_wr_en || w_revert) begin
            r_idle_cnt <= '0;
        end else if (r_driven) begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
        end
    end
`else
    assign w_revert = i_revert;
`endif

    // Channel register: a write takes priority over a revert so that a
    // write landing on the expiry edge keeps the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= DEF;
            r_driven <= 1'b0;
        end else if (i_wr_en) begin
            r_data   <= i_wr_data;
            r_driven <= 1'b1;
        end else if (w_revert) begin
            r_data   <= DEF;
            r_driven <= 1'b0;
        end
    end

    assign o_data   = r_data;
    assign o_driven = r_driven;

endmodule

// File: rtl/default_drive_bank.sv
// -----------------------------------------------------------------------------
// default_drive_bank
// Purpose : Bank of N registered channels, each WIDTH bits, that sit at
//           (DEFAULT_BASE + i) until written and can be swept back to their
//           defaults one channel per cycle.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           wr          - default_drive_bank_if.slave write port
//           sweep_req   - pulse: revert every channel, in index order
//           ch_data     - channel i at bits [i*WIDTH +: WIDTH]
//           ch_driven   - bit i set while channel i holds a written value
//           busy        - sweep in progress (write port stalled)
// Macro   : DEFAULT_DRIVE_BANK_TIMEOUT_EN enables per-channel idle reverts
//           after TIMEOUT cycles; otherwise TIMEOUT is unused.
// -----------------------------------------------------------------------------
module default_drive_bank
    import default_drive_bank_pkg::*;
#(
    parameter int N            = 4,
    parameter int WIDTH        = 5,
    parameter int DEFAULT_BASE = 9,
    parameter int TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    default_drive_bank_if.slave    wr,
    input  logic                   sweep_req,
    output logic [N*WIDTH-1:0]     ch_data,
    output logic [N-1:0]           ch_driven,
    output logic                   busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Reject out-of-range parameters at elaboration.
    if (N < 1 || N > 64 || WIDTH < 1 || WIDTH > 32 || TIMEOUT < 1) begin : g_param_check
        $error("default_drive_bank: parameter out of range");
    end

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_sweep_cnt;
    logic [IW-1:0] w_next_cnt;
    logic          w_fire;
    logic [N-1:0]  w_wr_en;
    logic [N-1:0]  w_revert;

    // State and sweep counter registers; reset abandons any sweep in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_sweep_cnt <= w_next_cnt;
        end
    end

    // Next-state logic: a sweep walks the counter 0..N-1 and then drops back
    // to IDLE; sweep_req is only looked at in IDLE, so requests made while
    // sweeping are simply dropped.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_sweep_cnt;
        case (r_state)
            IDLE: begin
                if (sweep_req) begin
                    w_next_state = SWEEP;
                    w_next_cnt   = '0;
                end
            end
            SWEEP: begin
                w_next_cnt = r_sweep_cnt + IW'(1);
                if (r_sweep_cnt == IW'(N - 1)) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign wr.wr_ready = (r_state == IDLE);
    assign busy        = (r_state == SWEEP);
    assign w_fire      = wr.wr_valid && wr.wr_ready;

    // One channel per index; an index with no matching channel still
    // completes the handshake but enables nothing.
    for (genvar i = 0; i < N; i++) begin : g_ch
        assign w_wr_en[i]  = w_fire && (wr.wr_idx == IW'(i));
        assign w_revert[i] = (r_state == SWEEP) && (r_sweep_cnt == IW'(i));

        default_drive_bank_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_VAL (default_value(DEFAULT_BASE, i, WIDTH))
`ifdef DEFAULT_DRIVE_BANK_TIMEOUT_EN
            ,
            .TIMEOUT     (TIMEOUT)
`endif
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en[i]),
            .i_wr_data (wr.wr_data),
            .i_revert  (w_revert[i]),
            .o_data    (ch_data[i*WIDTH +: WIDTH]),
            .o_driven  (ch_driven[i])
        );
    end

endmodule

// File: tb/tb_default_drive_bank.sv
// -----------------------------------------------------------------------------
// tb_default_drive_bank
// Purpose : Self-checking bench for default_drive_bank. Instance A (N=4) covers
//           reset, writes, sweeps and reset mid-sweep; instance B (N=3) covers
//           the out-of-range index; instance C (N=4, TIMEOUT=4) covers the idle
//           timeout when DEFAULT_DRIVE_BANK_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_default_drive_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, rstB;
    logic        sweepA, sweepB, sweepC;
    logic [19:0] dataA, dataC;
    logic [14:0] dataB;
    logic [3:0]  drvA, drvC;
    logic [2:0]  drvB;
    logic        busyA, busyB, busyC;

    default_drive_bank_if #(.IW(2), .WIDTH(5)) ifA ();
    default_drive_bank_if #(.IW(2), .WIDTH(5)) ifB ();
    default_drive_bank_if #(.IW(2), .WIDTH(5)) ifC ();

    default_drive_bank #(.N(4), .WIDTH(5), .DEFAULT_BASE(9), .TIMEOUT(1000)) dutA (
        .clk(clk), .rst(rstA), .wr(ifA), .sweep_req(sweepA),
        .ch_data(dataA), .ch_driven(drvA), .busy(busyA)
    );

    default_drive_bank #(.N(3), .WIDTH(5), .DEFAULT_BASE(9), .TIMEOUT(1000)) dutB (
        .clk(clk), .rst(rstB), .wr(ifB), .sweep_req(sweepB),
        .ch_data(dataB), .ch_driven(drvB), .busy(busyB)
    );

    default_drive_bank #(.N(4), .WIDTH(5), .DEFAULT_BASE(9), .TIMEOUT(4)) dutC (
        .clk(clk), .rst(rstB), .wr(ifC), .sweep_req(sweepC),
        .ch_data(dataC), .ch_driven(drvC), .busy(busyC)
    );

    typedef struct {
        int          due;
        int          sel;
        string       name;
        logic [19:0] data;
        logic [3:0]  drv;
        logic        rdy;
        logic        bsy;
    } exp_t;

    exp_t expQ[$];
    int   cyc   = 0;
    int   nVec  = 0;
    int   nFail = 0;
    bit   doneA = 1'b0;
    bit   doneB = 1'b0;
    bit   doneC = 1'b0;

    localparam logic [19:0] D4 = {5'd12, 5'd11, 5'd10, 5'd9};
    localparam logic [19:0] D3 = {5'd0, 5'd11, 5'd10, 5'd9};

    // Edge counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance's inputs for the coming edge.
    task automatic applyStimulus(input int sel, input logic v, input int idx, input int data, input logic sw);
        case (sel)
            0: begin ifA.wr_valid = v; ifA.wr_idx = 2'(idx); ifA.wr_data = 5'(data); sweepA = sw; end
            1: begin ifB.wr_valid = v; ifB.wr_idx = 2'(idx); ifB.wr_data = 5'(data); sweepB = sw; end
            default: begin ifC.wr_valid = v; ifC.wr_idx = 2'(idx); ifC.wr_data = 5'(data); sweepC = sw; end
        endcase
    endtask

    // Queue the expected outputs of one instance after the coming edge.
    task automatic expectOutput(input int sel, input string name, input logic [19:0] data,
                                input logic [3:0] drv, input logic rdy, input logic bsy);
        exp_t e;
        e.due  = cyc + 1;
        e.sel  = sel;
        e.name = name;
        e.data = data;
        e.drv  = drv;
        e.rdy  = rdy;
        e.bsy  = bsy;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [19:0] aData;
        logic [3:0]  aDrv;
        logic        aRdy, aBsy;
        case (e.sel)
            0: begin aData = dataA; aDrv = drvA; aRdy = ifA.wr_ready; aBsy = busyA; end
            1: begin aData = {5'd0, dataB}; aDrv = {1'b0, drvB}; aRdy = ifB.wr_ready; aBsy = busyB; end
            default: begin aData = dataC; aDrv = drvC; aRdy = ifC.wr_ready; aBsy = busyC; end
        endcase
        nVec++;
        if (e.due != cyc || aData !== e.data || aDrv !== e.drv || aRdy !== e.rdy || aBsy !== e.bsy) begin
            nFail++;
            $display("[TB] FAIL %s (due %0d, at %0d): got data=%h driven=%b ready=%b busy=%b, want data=%h driven=%b ready=%b busy=%b",
                     e.name, e.due, cyc, aData, aDrv, aRdy, aBsy, e.data, e.drv, e.rdy, e.bsy);
        end
    endtask

    // Monitor: on each falling edge, retire every expectation that is due.
    always @(negedge clk) begin
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].due <= cyc) begin
                checkOutput(expQ[i]);
                expQ.delete(i);
            end
        end
    end

    // Instance A: reset, writes, sweeps, write+sweep, reset mid-sweep.
    initial begin : threadA
        rstA = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        expectOutput(0, "A_reset_state", D4, 4'b0000, 1, 0);
        step();
        step();
        rstA = 1'b0;
        applyStimulus(0, 0, 0, 0, 0); expectOutput(0, "A_post_reset", D4, 4'b0000, 1, 0); step();
        applyStimulus(0, 1, 2, 31, 0); expectOutput(0, "A_write_idx2", pack4(12, 31, 10, 9), 4'b0100, 1, 0); step();
        applyStimulus(0, 0, 0, 0, 0);  expectOutput(0, "A_hold_idx2", pack4(12, 31, 10, 9), 4'b0100, 1, 0); step();
        applyStimulus(0, 1, 1, 3, 0);  expectOutput(0, "A_write_idx1", pack4(12, 31, 3, 9), 4'b0110, 1, 0); step();
        applyStimulus(0, 1, 3, 7, 0);  expectOutput(0, "A_write_idx3", pack4(7, 31, 3, 9), 4'b1110, 1, 0); step();
        applyStimulus(0, 0, 0, 0, 1);  expectOutput(0, "A_sweep_entry", pack4(7, 31, 3, 9), 4'b1110, 0, 1); step();
        applyStimulus(0, 1, 0, 21, 0); expectOutput(0, "A_sweep_ch0", pack4(7, 31, 3, 9), 4'b1110, 0, 1); step();
        expectOutput(0, "A_sweep_ch1", pack4(7, 31, 10, 9), 4'b1100, 0, 1); step();
        expectOutput(0, "A_sweep_ch2", pack4(7, 11, 10, 9), 4'b1000, 0, 1); step();
        expectOutput(0, "A_sweep_ch3", D4, 4'b0000, 1, 0); step();
        applyStimulus(0, 1, 0, 5, 1);  expectOutput(0, "A_wr_and_sweep", pack4(12, 11, 10, 5), 4'b0001, 0, 1); step();
        applyStimulus(0, 0, 0, 0, 0);  expectOutput(0, "A_ws_ch0_revert", D4, 4'b0000, 0, 1); step();
        applyStimulus(0, 0, 0, 0, 1);  expectOutput(0, "A_ws_req_ignored", D4, 4'b0000, 0, 1); step();
        applyStimulus(0, 0, 0, 0, 0);  expectOutput(0, "A_ws_ch2", D4, 4'b0000, 0, 1); step();
        expectOutput(0, "A_ws_done", D4, 4'b0000, 1, 0); step();
        expectOutput(0, "A_ws_not_extended", D4, 4'b0000, 1, 0); step();
        applyStimulus(0, 1, 2, 11, 0); expectOutput(0, "A_write_default_val", D4, 4'b0100, 1, 0); step();
        applyStimulus(0, 1, 3, 7, 0);  expectOutput(0, "A_pre_abort_write", pack4(7, 11, 10, 9), 4'b1100, 1, 0); step();
        applyStimulus(0, 0, 0, 0, 1);  expectOutput(0, "A_abort_entry", pack4(7, 11, 10, 9), 4'b1100, 0, 1); step();
        applyStimulus(0, 0, 0, 0, 0);  expectOutput(0, "A_abort_ch0", pack4(7, 11, 10, 9), 4'b1100, 0, 1); step();
        rstA = 1'b1;                   expectOutput(0, "A_reset_mid_sweep", D4, 4'b0000, 1, 0); step();
        rstA = 1'b0;                   expectOutput(0, "A_after_abort", D4, 4'b0000, 1, 0); step();
        step();
        doneA = 1'b1;
    end

    // Instance B (N=3): an index past the last channel is accepted and dropped.
    initial begin : threadB
        rstB = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        expectOutput(1, "B_reset_state", D3, 4'b0000, 1, 0);
        step();
        step();
        rstB = 1'b0;
        applyStimulus(1, 1, 3, 5, 0); expectOutput(1, "B_idx_out_of_range", D3, 4'b0000, 1, 0); step();
        applyStimulus(1, 0, 0, 0, 0); expectOutput(1, "B_after_oob", D3, 4'b0000, 1, 0); step();
        applyStimulus(1, 1, 2, 0, 0); expectOutput(1, "B_write_idx2", {5'd0, 5'd0, 5'd10, 5'd9}, 4'b0100, 1, 0); step();
        applyStimulus(1, 0, 0, 0, 0);
        step();
        doneB = 1'b1;
    end

    // Instance C (TIMEOUT=4): idle reverts, restart on rewrite, write beats expiry.
    initial begin : threadC
        applyStimulus(2, 0, 0, 0, 0);
`ifdef DEFAULT_DRIVE_BANK_TIMEOUT_EN
        expectOutput(2, "C_reset_state", D4, 4'b0000, 1, 0);
        step();
        step();
        applyStimulus(2, 1, 0, 1, 0); expectOutput(2, "C_write0", pack4(12, 11, 10, 1), 4'b0001, 1, 0); step();
        applyStimulus(2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expectOutput(2, "C_hold0", pack4(12, 11, 10, 1), 4'b0001, 1, 0); step();
        end
        expectOutput(2, "C_timeout0", D4, 4'b0000, 1, 0); step();
        applyStimulus(2, 1, 1, 2, 0); expectOutput(2, "C_write1", pack4(12, 11, 2, 9), 4'b0010, 1, 0); step();
        applyStimulus(2, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            expectOutput(2, "C_hold1", pack4(12, 11, 2, 9), 4'b0010, 1, 0); step();
        end
        applyStimulus(2, 1, 1, 6, 0); expectOutput(2, "C_rewrite1", pack4(12, 11, 6, 9), 4'b0010, 1, 0); step();
        applyStimulus(2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expectOutput(2, "C_hold_rewrite", pack4(12, 11, 6, 9), 4'b0010, 1, 0); step();
        end
        applyStimulus(2, 1, 1, 8, 0); expectOutput(2, "C_write_beats_expiry", pack4(12, 11, 8, 9), 4'b0010, 1, 0); step();
        applyStimulus(2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expectOutput(2, "C_hold_after_tie", pack4(12, 11, 8, 9), 4'b0010, 1, 0); step();
        end
        expectOutput(2, "C_timeout1", D4, 4'b0000, 1, 0); step();
        step();
`endif
        doneC = 1'b1;
    end

    // Wait for every stimulus thread under a cycle budget, then summarise.
    initial begin : mainSeq
        for (int k = 0; k < 500 && !(doneA && doneB && doneC); k++) begin
            @(posedge clk);
        end
        if (!(doneA && doneB && doneC)) begin
            nVec++;
            nFail++;
            $display("[TB] FAIL stimulus_timeout: threads done A=%0b B=%0b C=%0b, want all 1", doneA, doneB, doneC);
        end
        repeat (2) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            nVec  += expQ.size();
            nFail += expQ.size();
            $display("[TB] FAIL unretired_expectations: %0d left in queue, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
